// File: rtl/snes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module      : snes_pad_responder
//  Description : Controller-side end of the SNES latch/clock serial protocol.
//                Conditions the console lat/clk pins and shifts out one
//                16-bit button word per latch on snes_dat (low = pressed).
//                Words come from an upstream frame source via valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module snes_pad_responder #(
    parameter int FILTER_CYCLES    = 3,
    parameter int HOLD_ON_UNDERRUN = 1,
    parameter int CNT_W            = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             snes_lat,
    input  logic             snes_clk,
    output logic             snes_dat,
    input  logic [15:0]      frame_data,
    input  logic             frame_valid,
    output logic             frame_ready,
    output logic             underrun,
    output logic [CNT_W-1:0] latch_count,
    output logic [4:0]       bit_idx
);

    // Filter counter only needs to reach FILTER_CYCLES-1.
    localparam int                c_FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [c_FCNT_W-1:0] c_FMAX = c_FCNT_W'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCHED = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    logic                r_lat_s1, r_lat_s2, r_clk_s1, r_clk_s2;
    logic                r_lat_f, r_clk_f, r_lat_fd, r_clk_fd;
    logic [c_FCNT_W-1:0] r_lat_cnt, r_clk_cnt;

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_sr, w_sr_nxt;
    logic [15:0]         r_last, w_last_nxt;
    logic [15:0]         r_load, w_load_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [4:0]          r_idx, w_idx_nxt;
    logic                r_dat, w_dat_nxt;
    logic                w_ready, w_underrun;
    logic                w_lat_rise, w_clk_rise;

    // Two-flop synchronizers; lat idles low, clk idles high.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_s1 <= 1'b0;
            r_lat_s2 <= 1'b0;
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
        end else begin
            r_lat_s1 <= snes_lat;
            r_lat_s2 <= r_lat_s1;
            r_clk_s1 <= snes_clk;
            r_clk_s2 <= r_clk_s1;
        end
    end

    // Latch stability filter: adopt a new level after FILTER_CYCLES differing samples in a row.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_f   <= 1'b0;
            r_lat_cnt <= '0;
        end else if (r_lat_s2 == r_lat_f) begin
            r_lat_cnt <= '0;
        end else if (r_lat_cnt == c_FMAX) begin
            r_lat_f   <= r_lat_s2;
            r_lat_cnt <= '0;
        end else begin
            r_lat_cnt <= r_lat_cnt + c_FCNT_W'(1);
        end
    end

    // Clock stability filter, same rule as the latch filter.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_f   <= 1'b1;
            r_clk_cnt <= '0;
        end else if (r_clk_s2 == r_clk_f) begin
            r_clk_cnt <= '0;
        end else if (r_clk_cnt == c_FMAX) begin
            r_clk_f   <= r_clk_s2;
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + c_FCNT_W'(1);
        end
    end

    // Delayed filtered levels for edge detection.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_fd <= 1'b0;
            r_clk_fd <= 1'b1;
        end else begin
            r_lat_fd <= r_lat_f;
            r_clk_fd <= r_clk_f;
        end
    end

    assign w_lat_rise = r_lat_f & ~r_lat_fd;
    assign w_clk_rise = r_clk_f & ~r_clk_fd;

    // Protocol state and datapath registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_last  <= '0;
            r_load  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dat   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_last  <= w_last_nxt;
            r_load  <= w_load_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dat   <= w_dat_nxt;
        end
    end

    // Next-state logic; a latch rise overrides everything, including a coincident clk rise.
    // r_load holds the word chosen at the latch edge so the parallel-load phase
    // keeps presenting it (released word on underrun when not holding).
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_last_nxt  = r_last;
        w_load_nxt  = r_load;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_ready     = 1'b0;
        w_underrun  = 1'b0;

        if (w_lat_rise) begin
            w_ready     = 1'b1;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_idx_nxt   = 5'd0;
            w_state_nxt = ST_LATCHED;
            if (frame_valid) begin
                w_sr_nxt   = frame_data;
                w_last_nxt = frame_data;
                w_load_nxt = frame_data;
            end else begin
                w_underrun = 1'b1;
                w_load_nxt = (HOLD_ON_UNDERRUN != 0) ? r_last : 16'h0000;
                w_sr_nxt   = w_load_nxt;
            end
        end else begin
            case (r_state)
                ST_LATCHED: begin
                    w_sr_nxt = r_load;
                    if (!r_lat_f) begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_clk_rise) begin
                        w_sr_nxt  = {1'b1, r_sr[15:1]};
                        w_idx_nxt = r_idx + 5'd1;
                        if (r_idx == 5'd15) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        w_dat_nxt = (w_state_nxt == ST_IDLE) ? 1'b1 : ~w_sr_nxt[0];
    end

    assign snes_dat    = r_dat;
    assign frame_ready = w_ready;
    assign underrun    = w_underrun;
    assign latch_count = r_cnt;
    assign bit_idx     = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_snes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snes_pad_responder
//  Description : Directed self-checking bench. Instance A uses defaults
//                (hold on underrun); instance B releases on underrun and has
//                a 4-bit latch counter so wrap-around is reachable quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snes_pad_responder;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        snes_lat = 1'b0;
    logic        snes_clk = 1'b1;
    logic [15:0] frame_data = 16'h0000;
    logic        frame_valid = 1'b0;

    logic        dat_a, rdy_a, und_a;
    logic [15:0] cnt_a;
    logic [4:0]  idx_a;
    logic        dat_b, rdy_b, und_b;
    logic [3:0]  cnt_b;
    logic [4:0]  idx_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_rdy_a = 0, n_rdy_b = 0, n_und_a = 0, n_und_b = 0;

    snes_pad_responder u_dut_a (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .snes_lat    (snes_lat),
        .snes_clk    (snes_clk),
        .snes_dat    (dat_a),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (rdy_a),
        .underrun    (und_a),
        .latch_count (cnt_a),
        .bit_idx     (idx_a)
    );

    snes_pad_responder #(
        .FILTER_CYCLES    (3),
        .HOLD_ON_UNDERRUN (0),
        .CNT_W            (4)
    ) u_dut_b (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .snes_lat    (snes_lat),
        .snes_clk    (snes_clk),
        .snes_dat    (dat_b),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (rdy_b),
        .underrun    (und_b),
        .latch_count (cnt_b),
        .bit_idx     (idx_b)
    );

    always #10 sys_clk = ~sys_clk;

    // Count strobe pulses; each pulse spans exactly one negedge.
    always @(negedge sys_clk) begin
        if (rdy_a) n_rdy_a++;
        if (rdy_b) n_rdy_b++;
        if (und_a) n_und_a++;
        if (und_b) n_und_b++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Full latch pulse with a word presented (valid) or not.
    task automatic do_latch(input logic v, input logic [15:0] d);
        @(negedge sys_clk);
        frame_valid = v;
        frame_data  = d;
        snes_lat    = 1'b1;
        wait_cyc(12);
        snes_lat    = 1'b0;
        wait_cyc(10);
    endtask

    // One console clock: low 8 cycles, rise, settle 10 cycles.
    task automatic clk_pulse();
        snes_clk = 1'b0;
        wait_cyc(8);
        snes_clk = 1'b1;
        wait_cyc(10);
    endtask

    // Read bits [from..to-1] as the console would (sample, then clock).
    task automatic read_bits(input int from, input int to,
                             inout logic [15:0] wa, inout logic [15:0] wb);
        for (int k = from; k < to; k++) begin
            wa[k] = ~dat_a;
            wb[k] = ~dat_b;
            clk_pulse();
        end
    endtask

    logic [15:0] wa, wb;
    int r0, u0;
    int n_latch;

    initial begin
        // ---------------- reset ----------------
        wait_cyc(4);
        chk("rst_dat_a", dat_a, 1);
        chk("rst_rdy_a", rdy_a, 0);
        chk("rst_und_a", und_a, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_idx_a", idx_a, 0);
        chk("rst_dat_b", dat_b, 1);
        @(negedge sys_clk);
        rst_n = 1'b1;
        wait_cyc(4);
        chk("idle_dat_a", dat_a, 1);
        chk("idle_rdy_cnt", n_rdy_a, 0);

        // ---------------- basic frame 0101 ----------------
        r0 = n_rdy_a;
        u0 = n_und_a;
        do_latch(1'b1, 16'h0101);
        chk("f1_ready_pulses", n_rdy_a - r0, 1);
        chk("f1_no_underrun", n_und_a - u0, 0);
        chk("f1_idx_after_latch", idx_a, 0);
        chk("f1_bit0_low", dat_a, 0);
        wa = '0; wb = '0;
        read_bits(0, 8, wa, wb);
        chk("f1_bit8_low", dat_a, 0);
        chk("f1_idx8", idx_a, 8);
        read_bits(8, 16, wa, wb);
        chk("f1_word_a", wa, 16'h0101);
        chk("f1_word_b", wb, 16'h0101);
        chk("f1_done_dat", dat_a, 0);
        chk("f1_done_idx", idx_a, 16);
        chk("f1_count", cnt_a, 1);
        clk_pulse();
        chk("f1_extra_idx", idx_a, 16);
        chk("f1_extra_dat", dat_a, 0);

        // ---------------- underrun: hold (A) vs release (B) ----------------
        u0 = n_und_a;
        do_latch(1'b1, 16'h0010);
        wa = '0; wb = '0;
        read_bits(0, 16, wa, wb);
        chk("u1_word_a", wa, 16'h0010);
        chk("u1_word_b", wb, 16'h0010);
        do_latch(1'b0, 16'hFFFF);
        wa = '0; wb = '0;
        read_bits(0, 16, wa, wb);
        chk("u2_word_a", wa, 16'h0010);
        chk("u2_word_b", wb, 16'h0000);
        do_latch(1'b0, 16'hFFFF);
        wa = '0; wb = '0;
        read_bits(0, 16, wa, wb);
        chk("u3_word_a", wa, 16'h0010);
        chk("u3_word_b", wb, 16'h0000);
        chk("u_underruns_a", n_und_a - u0, 2);
        chk("u_underruns_b", n_und_b - u0, 2);
        chk("u_count_a", cnt_a, 4);

        // ---------------- aborted transfer ----------------
        do_latch(1'b1, 16'h1234);
        wa = '0; wb = '0;
        read_bits(0, 5, wa, wb);
        chk("ab_idx5", idx_a, 5);
        do_latch(1'b1, 16'h8000);
        chk("ab_idx0", idx_a, 0);
        chk("ab_count", cnt_a, 6);
        wa = '0; wb = '0;
        read_bits(0, 15, wa, wb);
        chk("ab_bit15_low", dat_a, 0);
        read_bits(15, 16, wa, wb);
        chk("ab_word_a", wa, 16'h8000);

        // ---------------- clk pulses during latch, glitches mid-shift ----------------
        @(negedge sys_clk);
        frame_valid = 1'b1;
        frame_data  = 16'h0F0F;
        snes_lat    = 1'b1;
        wait_cyc(8);
        for (int p = 0; p < 2; p++) begin
            snes_clk = 1'b0;
            wait_cyc(8);
            snes_clk = 1'b1;
            wait_cyc(8);
        end
        snes_lat = 1'b0;
        wait_cyc(10);
        chk("gl_idx_latch_clk", idx_a, 0);
        wa = '0; wb = '0;
        read_bits(0, 3, wa, wb);
        r0 = n_rdy_a;
        snes_clk = 1'b0; wait_cyc(1); snes_clk = 1'b1; wait_cyc(4);
        snes_clk = 1'b0; wait_cyc(2); snes_clk = 1'b1; wait_cyc(4);
        snes_lat = 1'b1; wait_cyc(1); snes_lat = 1'b0; wait_cyc(4);
        snes_lat = 1'b1; wait_cyc(2); snes_lat = 1'b0; wait_cyc(10);
        chk("gl_idx", idx_a, 3);
        chk("gl_count", cnt_a, 7);
        chk("gl_no_ready", n_rdy_a - r0, 0);
        read_bits(3, 16, wa, wb);
        chk("gl_word_a", wa, 16'h0F0F);

        // ---------------- reset mid-frame ----------------
        do_latch(1'b1, 16'h3C5A);
        wa = '0; wb = '0;
        read_bits(0, 8, wa, wb);
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        chk("mr_dat_a", dat_a, 1);
        chk("mr_idx_a", idx_a, 0);
        chk("mr_cnt_a", cnt_a, 0);
        chk("mr_rdy_a", rdy_a, 0);
        chk("mr_und_a", und_a, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        do_latch(1'b1, 16'hA5C3);
        wa = '0; wb = '0;
        read_bits(0, 16, wa, wb);
        chk("mr_word_a", wa, 16'hA5C3);
        chk("mr_word_b", wb, 16'hA5C3);
        chk("mr_count", cnt_a, 1);

        // ---------------- counter wrap (B is 4 bits wide) ----------------
        n_latch = 1;
        while (n_latch < 15) begin
            @(negedge sys_clk);
            frame_valid = 1'b1;
            snes_lat = 1'b1;
            wait_cyc(8);
            snes_lat = 1'b0;
            wait_cyc(8);
            n_latch++;
        end
        chk("wr_cnt_a15", cnt_a, 15);
        chk("wr_cnt_b15", cnt_b, 15);
        do_latch(1'b1, 16'h0001);
        chk("wr_cnt_a16", cnt_a, 16);
        chk("wr_cnt_b_wrap", cnt_b, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
